// File: rtl/clk_div_pkg.sv
// Shared definitions for the reference-clock divider sequencer.
package clk_div_pkg;

    localparam int RATIO_W = 8;
    localparam logic [RATIO_W-1:0] RATIO_BYPASS  = 8'd1;
    localparam logic [RATIO_W-1:0] RATIO_INVALID = 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        HOLD,
        ENABLE,
        DONE
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio-change handshake plus the control lines driven into the divider.
interface clk_div_ctrl_if;
    import clk_div_pkg::*;

    logic               i_cfg_req;
    logic [RATIO_W-1:0] i_cfg_ratio;
    logic               o_cfg_ack;
    logic               o_cfg_err;
    logic [RATIO_W-1:0] o_div_ratio;
    logic               o_div_clk_en;
    logic               o_div_rst_n;
    logic               o_busy;

    modport master (
        output i_cfg_req, i_cfg_ratio,
        input  o_cfg_ack, o_cfg_err, o_div_ratio, o_div_clk_en, o_div_rst_n, o_busy
    );

    modport slave (
        input  i_cfg_req, i_cfg_ratio,
        output o_cfg_ack, o_cfg_err, o_div_ratio, o_div_clk_en, o_div_rst_n, o_busy
    );

endinterface

// File: rtl/clk_div_seq_counter.sv
// Loadable down-counter timing the DRAIN and HOLD phases; saturates at zero.
module clk_div_seq_counter
    import clk_div_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [RATIO_W-1:0] load_value,
    output logic               zero
);

    logic [RATIO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer that validates divide-ratio requests and applies them glitch-safely:
// drain the current period, hold the divider in reset, load the ratio, re-enable.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DEFAULT_RATIO = 8,
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic           i_ref_clk,
    input  logic           i_rst_n,
    clk_div_ctrl_if.slave  bus
);

    localparam logic [RATIO_W-1:0] DEFAULT_VAL = RATIO_W'(DEFAULT_RATIO);
    localparam logic [RATIO_W-1:0] SETTLE_LOAD = RATIO_W'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [RATIO_W-1:0] div_ratio;
    logic [RATIO_W-1:0] pending;
    logic               div_rst_n;
    logic               clk_en;
    logic               cfg_ack;
    logic               cfg_err;
    logic               busy;
    logic               req_armed;
    logic               in_txn;

    logic               accept;
    logic               is_change;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [RATIO_W-1:0] cnt_value;

    assign accept    = (state == IDLE) && bus.i_cfg_req && req_armed;
    assign is_change = (bus.i_cfg_ratio != RATIO_INVALID) && (bus.i_cfg_ratio != div_ratio);

    // Counter is loaded on entry to DRAIN/HOLD and counts down while there.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = '0;
        case (state)
            IDLE: begin
                if (accept && is_change) begin
                    cnt_load  = 1'b1;
                    cnt_value = (div_ratio == RATIO_BYPASS) ? SETTLE_LOAD : (div_ratio - 8'd1);
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = SETTLE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD:    cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    clk_div_seq_counter u_counter (
        .clk        (i_ref_clk),
        .rst_n      (i_rst_n),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state     <= HOLD;
            div_ratio <= DEFAULT_VAL;
            pending   <= DEFAULT_VAL;
            div_rst_n <= 1'b0;
            clk_en    <= 1'b0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b1;
            req_armed <= 1'b0;
            in_txn    <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            if (!bus.i_cfg_req) begin
                req_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_armed <= 1'b0;
                        busy      <= 1'b1;
                        in_txn    <= 1'b1;
                        if (bus.i_cfg_ratio == RATIO_INVALID) begin
                            state   <= DONE;
                            cfg_ack <= 1'b1;
                            cfg_err <= 1'b1;
                        end else if (bus.i_cfg_ratio == div_ratio) begin
                            state   <= DONE;
                            cfg_ack <= 1'b1;
                        end else begin
                            pending <= bus.i_cfg_ratio;
                            // In bypass there is no divided period to drain.
                            if (div_ratio == RATIO_BYPASS) begin
                                state     <= HOLD;
                                div_ratio <= bus.i_cfg_ratio;
                                div_rst_n <= 1'b0;
                                clk_en    <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_zero) begin
                        state     <= HOLD;
                        div_ratio <= pending;
                        div_rst_n <= 1'b0;
                        clk_en    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state     <= ENABLE;
                        div_rst_n <= 1'b1;
                    end
                end
                ENABLE: begin
                    // Enable follows reset release by a cycle so it is never high in reset.
                    clk_en <= (div_ratio > RATIO_BYPASS);
                    if (in_txn) begin
                        state   <= DONE;
                        cfg_ack <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    in_txn <= 1'b0;
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.o_cfg_ack    = cfg_ack;
    assign bus.o_cfg_err    = cfg_err;
    assign bus.o_div_ratio  = div_ratio;
    assign bus.o_div_clk_en = clk_en;
    assign bus.o_div_rst_n  = div_rst_n;
    assign bus.o_busy       = busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against a timeline model of each ratio-change transaction.
module tb_clk_div_ctrl;

    localparam int DEFAULT = 8;
    localparam int SETTLE  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   model_ratio  = DEFAULT;

    always #5 clk = ~clk;

    clk_div_ctrl_if bus();

    clk_div_ctrl #(
        .DEFAULT_RATIO (DEFAULT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    // Observation index k counts edges after acceptance; ack is seen at k = drain + SETTLE + 2.
    function automatic int ack_cycle(input int cur, input int nw);
        if (nw == 0 || nw == cur) return 1;
        return ((cur == 1) ? 0 : cur) + SETTLE + 2;
    endfunction

    function automatic void expect_at(input int cur, input int nw, input int k,
                                      output int r, output bit rn, output bit en,
                                      output bit ack, output bit err, output bit busy);
        int ak;
        int hold_start;
        ak   = ack_cycle(cur, nw);
        busy = (k <= ak);
        ack  = (k == ak);
        err  = ack && (nw == 0);
        if (nw == 0 || nw == cur) begin
            r  = cur;
            rn = 1'b1;
            en = (cur >= 2);
        end else begin
            hold_start = ((cur == 1) ? 0 : cur) + 1;
            r  = (k < hold_start) ? cur : nw;
            rn = !(k >= hold_start && k < hold_start + SETTLE);
            en = (k < hold_start) ? (cur >= 2) : (k >= ak && nw >= 2);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_cfg_req   = 1'b0;
        bus.i_cfg_ratio = 8'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.o_div_ratio !== 8'(DEFAULT) || bus.o_div_rst_n !== 1'b0 || bus.o_div_clk_en !== 1'b0 ||
            bus.o_cfg_ack !== 1'b0 || bus.o_cfg_err !== 1'b0 || bus.o_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got ratio=%0d rst_n=%b en=%b ack=%b err=%b busy=%b, expected %0d 0 0 0 0 1",
                     bus.o_div_ratio, bus.o_div_rst_n, bus.o_div_clk_en, bus.o_cfg_ack, bus.o_cfg_err, bus.o_busy, DEFAULT);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.o_div_rst_n !== 1'b1 || bus.o_div_clk_en !== (k >= 2) || bus.o_busy !== (k < 2) ||
                bus.o_cfg_ack !== 1'b0 || bus.o_div_ratio !== 8'(DEFAULT)) begin
                tests_failed++;
                $display("[TB] FAIL reset_release k=%0d: got rst_n=%b en=%b busy=%b ack=%b ratio=%0d, expected 1 %b %b 0 %0d",
                         k, bus.o_div_rst_n, bus.o_div_clk_en, bus.o_busy, bus.o_cfg_ack, bus.o_div_ratio,
                         k >= 2, k < 2, DEFAULT);
            end
        end
        model_ratio = DEFAULT;
    endtask

    task automatic test_transaction(input int nw, input bit drop_req);
        int cur;
        int ak;
        int er;
        bit ern, een, eack, eerr, ebusy;
        cur = model_ratio;
        ak  = ack_cycle(cur, nw);
        @(negedge clk);
        bus.i_cfg_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_before_req: busy got %b expected 0", bus.o_busy);
        end
        bus.i_cfg_req   = 1'b1;
        bus.i_cfg_ratio = 8'(nw);
        for (int k = 1; k <= ak + 1; k++) begin
            @(negedge clk);
            bus.i_cfg_ratio = 8'($urandom);
            if (drop_req && k == 2) bus.i_cfg_req = 1'b0;
            expect_at(cur, nw, k, er, ern, een, eack, eerr, ebusy);
            tests_run += 6;
            if (bus.o_div_ratio !== 8'(er)) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d ratio: got %0d expected %0d", cur, nw, k, bus.o_div_ratio, er);
            end
            if (bus.o_div_rst_n !== ern) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d div_rst_n: got %b expected %b", cur, nw, k, bus.o_div_rst_n, ern);
            end
            if (bus.o_div_clk_en !== een) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d clk_en: got %b expected %b", cur, nw, k, bus.o_div_clk_en, een);
            end
            if (bus.o_cfg_ack !== eack) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d ack: got %b expected %b", cur, nw, k, bus.o_cfg_ack, eack);
            end
            if (bus.o_cfg_err !== eerr) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d err: got %b expected %b", cur, nw, k, bus.o_cfg_err, eerr);
            end
            if (bus.o_busy !== ebusy) begin
                tests_failed++;
                $display("[TB] FAIL txn %0d->%0d k=%0d busy: got %b expected %b", cur, nw, k, bus.o_busy, ebusy);
            end
            if (k == ak) bus.i_cfg_req = 1'b0;
        end
        if (nw != 0) model_ratio = nw;
    endtask

    task automatic test_reject();
        test_transaction(0, 1'b0);
    endtask

    task automatic test_same_ratio();
        test_transaction(model_ratio, 1'b0);
    endtask

    task automatic test_ratio_change();
        test_transaction(4, 1'b0);
        test_transaction(8, 1'b1);
    endtask

    task automatic test_bypass();
        test_transaction(1, 1'b0);
        test_transaction(6, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.i_cfg_req = 1'b0;
        @(negedge clk);
        bus.i_cfg_req   = 1'b1;
        bus.i_cfg_ratio = 8'd0;
        @(negedge clk);
        tests_run++;
        if (bus.o_cfg_ack !== 1'b1 || bus.o_cfg_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_ack: got ack=%b err=%b expected 1 1", bus.o_cfg_ack, bus.o_cfg_err);
        end
        bus.i_cfg_ratio = 8'((model_ratio == 5) ? 6 : 5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.o_busy !== 1'b0 || bus.o_cfg_ack !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_held_req k=%0d: got busy=%b ack=%b expected 0 0", k, bus.o_busy, bus.o_cfg_ack);
            end
        end
        bus.i_cfg_req = 1'b0;
        @(negedge clk);
        bus.i_cfg_req   = 1'b1;
        bus.i_cfg_ratio = 8'd0;
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b1 || bus.o_cfg_ack !== 1'b1 || bus.o_cfg_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_rearm: got busy=%b ack=%b err=%b expected 1 1 1", bus.o_busy, bus.o_cfg_ack, bus.o_cfg_err);
        end
        bus.i_cfg_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0 || bus.o_cfg_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_end: got busy=%b ack=%b expected 0 0", bus.o_busy, bus.o_cfg_ack);
        end
    endtask

    task automatic test_reset_mid();
        int cur;
        int hs;
        cur = model_ratio;
        hs  = ((cur == 1) ? 0 : cur) + 1;
        @(negedge clk);
        bus.i_cfg_req = 1'b0;
        @(negedge clk);
        bus.i_cfg_req   = 1'b1;
        bus.i_cfg_ratio = 8'd3;
        for (int k = 1; k <= hs; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.o_div_ratio !== 8'((k < hs) ? cur : 3) || bus.o_div_rst_n !== (k < hs)) begin
                tests_failed++;
                $display("[TB] FAIL mid_seq k=%0d: got ratio=%0d rst_n=%b expected %0d %b",
                         k, bus.o_div_ratio, bus.o_div_rst_n, (k < hs) ? cur : 3, k < hs);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_div_ratio !== 8'(DEFAULT) || bus.o_div_rst_n !== 1'b0 || bus.o_div_clk_en !== 1'b0 ||
            bus.o_cfg_ack !== 1'b0 || bus.o_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_state: got ratio=%0d rst_n=%b en=%b ack=%b busy=%b expected %0d 0 0 0 1",
                     bus.o_div_ratio, bus.o_div_rst_n, bus.o_div_clk_en, bus.o_cfg_ack, bus.o_busy, DEFAULT);
        end
        bus.i_cfg_req = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.o_cfg_ack !== 1'b0 || bus.o_div_clk_en !== (k >= 2) || bus.o_busy !== (k < 2) ||
                bus.o_div_ratio !== 8'(DEFAULT) || bus.o_div_rst_n !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset_recover k=%0d: got ack=%b en=%b busy=%b ratio=%0d rst_n=%b expected 0 %b %b %0d 1",
                         k, bus.o_cfg_ack, bus.o_div_clk_en, bus.o_busy, bus.o_div_ratio, bus.o_div_rst_n,
                         k >= 2, k < 2, DEFAULT);
            end
        end
        model_ratio = DEFAULT;
    endtask

    task automatic test_boundary();
        test_transaction(255, 1'b0);
        test_transaction(2, 1'b1);
        test_transaction(1, 1'b1);
        test_transaction(1, 1'b0);
        test_transaction(0, 1'b0);
        test_transaction(2, 1'b0);
    endtask

    task automatic test_random();
        int sel;
        int nw;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       nw = 0;
                1:       nw = model_ratio;
                2:       nw = 1;
                default: nw = $urandom_range(2, 16);
            endcase
            test_transaction(nw, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_reject();
        test_same_ratio();
        test_ratio_change();
        test_bypass();
        test_back_to_back();
        test_transaction(8, 1'b0);
        test_reset_mid();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
